spi_mem_arbiter: RTL

Sequences the single SPI memory engine and shares it between two requesters. The instruction-fetch port reads the program ROM at the PC. The data port reads or writes the SPI RAM at the MAR. The block does four things:
- arbitrates between the two ports;
- latches the winning request;
- drives the engine's start/address/write/data inputs;
- routes the engine's chip-select to the ROM or RAM select pin, then returns read data with a one-cycle acknowledge.

It sits between the control unit / MAR logic and the spi engine, replacing ad-hoc cs muxing at top level.

---
 rtl/spi_mem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI memory engine between the instruction-fetch port (ROM) and the
// data port (RAM): arbitrates, latches the winner, steers chip-select, acks once.
module spi_mem_arbiter #(
    parameter int          ADDR_W         = 16,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  ABORT_DATA     = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [7:0]        fetch_data,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [7:0]        data_wdata,
    output logic              data_ack,
    output logic [7:0]        data_rdata,
    output logic              spi_start,
    output logic              spi_write,
    output logic [ADDR_W-1:0] spi_addr,
    output logic [7:0]        spi_wdata,
    input  logic              spi_done,
    input  logic [7:0]        spi_rdata,
    input  logic              spi_cs,
    output logic              cs_rom,
    output logic              cs_ram,
    output logic              busy,
    output logic              timeout_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic       {G_FETCH, G_DATA}  port_t;

    state_t            state, next_state;
    port_t             grant, last_grant, winner;
    logic              take_grant, capture_done, abort;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q, rdata_q;
    logic              write_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state   = state;
        take_grant   = 1'b0;
        winner       = last_grant;
        capture_done = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req || data_req) begin
                    take_grant = 1'b1;
                    next_state = WAIT;
                    // On a tie the port that did not win last time goes first.
                    if (fetch_req && data_req)
                        winner = (last_grant == G_FETCH) ? G_DATA : G_FETCH;
                    else
                        winner = fetch_req ? G_FETCH : G_DATA;
                end
            end
            WAIT: begin
                if (spi_done) begin
                    capture_done = 1'b1;
                    next_state   = RESP;
                end else if (cnt == CNT_LAST) begin
                    abort      = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= G_FETCH;
            last_grant  <= G_DATA;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (take_grant) begin
                grant      <= winner;
                last_grant <= winner;
                if (winner == G_DATA) begin
                    addr_q  <= data_addr;
                    write_q <= data_we;
                    wdata_q <= data_wdata;
                end else begin
                    addr_q  <= fetch_addr;
                    write_q <= 1'b0;
                    wdata_q <= '0;
                end
            end
            if (state == RESP) grant <= G_FETCH;
            if (capture_done) rdata_q <= spi_rdata;
            if (abort) begin
                rdata_q     <= ABORT_DATA;
                timeout_err <= 1'b1;
            end
            if (state == WAIT && next_state == WAIT)
                cnt <= (cnt == CNT_LAST) ? cnt : cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    // Start is decoded from state so an async reset drops it immediately.
    assign spi_start  = (state == WAIT);
    assign spi_write  = write_q;
    assign spi_addr   = addr_q;
    assign spi_wdata  = wdata_q;
    assign busy       = (state != IDLE);

    assign fetch_ack  = (state == RESP) && (grant == G_FETCH);
    assign data_ack   = (state == RESP) && (grant == G_DATA);
    assign fetch_data = fetch_ack ? rdata_q : 8'h00;
    assign data_rdata = (data_ack && !write_q) ? rdata_q : 8'h00;

    assign cs_rom = (busy && grant == G_FETCH) ? spi_cs : 1'b1;
    assign cs_ram = (busy && grant == G_DATA)  ? spi_cs : 1'b1;

endmodule
